// File: rtl/ut_seq_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : ut_seq_datapath_if
// Description : Instruction handshake, status and debug-read bundle for the
//               self-sequenced processing unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ut_seq_datapath_if #(
    parameter int XLEN = 32,
    parameter int NREG = 8
);
    localparam int c_RW = $clog2(NREG);

    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic            done;
    logic            illegal;
    logic            busy;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] databus;
    logic            alu_carry;
    logic [c_RW-1:0] dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;

    modport master (
        output instr_valid, instr, dbg_raddr,
        input  instr_ready, done, illegal, busy, pc, databus, alu_carry, dbg_rdata
    );

    modport slave (
        input  instr_valid, instr, dbg_raddr,
        output instr_ready, done, illegal, busy, pc, databus, alu_carry, dbg_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ut_seq_datapath.sv
`default_nettype none
// ============================================================================
// Module      : ut_seq_datapath
// Description : Shared-bus datapath (RF, A/B, ALU, immediate, PC) sequenced
//               internally; executes one RV32 OP/OP-IMM per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ut_seq_datapath #(
    parameter int XLEN    = 32,
    parameter int NREG    = 8,
    parameter int PC_STEP = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ut_seq_datapath_if.slave bus
);
    localparam int              c_RW      = $clog2(NREG);
    localparam logic [31:0]     c_NREG    = 32'(NREG);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(PC_STEP);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RS1  = 2'd1;
    localparam logic [1:0] c_RS2  = 2'd2;
    localparam logic [1:0] c_WB   = 2'd3;

    logic [1:0]      r_state;
    logic            r_ir_op;      // 1: register-register OP, 0: OP-IMM
    logic            r_ir_sub;
    logic [2:0]      r_ir_f3;
    logic [c_RW-1:0] r_ir_rd;
    logic [c_RW-1:0] r_ir_rs1;
    logic [c_RW-1:0] r_ir_rs2;
    logic [11:0]     r_ir_imm;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_pc;
    logic            r_carry;
    logic            r_done;
    logic            r_illegal;
    logic [XLEN-1:0] r_rf [NREG];

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_is_op;
    logic            w_is_opi;
    logic            w_f3_ok;
    logic            w_fn_ok;
    logic            w_idx_ok;
    logic            w_legal;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_alu;
    logic            w_carry;
    logic [XLEN-1:0] w_bus;

    // Decode is evaluated straight off the offered instruction so that a
    // rejected one never disturbs the instruction register.
    always_comb begin
        w_opc    = bus.instr[6:0];
        w_f3     = bus.instr[14:12];
        w_f7     = bus.instr[31:25];
        w_is_op  = (w_opc == 7'b0110011);
        w_is_opi = (w_opc == 7'b0010011);
        w_f3_ok  = (w_f3 == 3'b000) || (w_f3 == 3'b100) ||
                   (w_f3 == 3'b110) || (w_f3 == 3'b111);
        w_fn_ok  = 1'b0;
        if (w_is_opi) begin
            w_fn_ok = w_f3_ok;
        end else if (w_is_op) begin
            w_fn_ok = ((w_f7 == 7'b0000000) && w_f3_ok) ||
                      ((w_f7 == 7'b0100000) && (w_f3 == 3'b000));
        end
        w_idx_ok = (32'(bus.instr[11:7])  < c_NREG) &&
                   (32'(bus.instr[19:15]) < c_NREG) &&
                   (!w_is_op || (32'(bus.instr[24:20]) < c_NREG));
        w_legal  = w_fn_ok && w_idx_ok;
    end

    assign w_rs1_val = (r_ir_rs1 == '0) ? '0 : r_rf[r_ir_rs1];
    assign w_rs2_val = (r_ir_rs2 == '0) ? '0 : r_rf[r_ir_rs2];
    assign w_imm     = {{(XLEN-12){r_ir_imm[11]}}, r_ir_imm};

    // Subtraction as A + ~B + 1 so the carry-out doubles as "A >= B".
    always_comb begin
        if (r_ir_sub) begin
            w_sum = {1'b0, r_a} + {1'b0, ~r_b} + {{XLEN{1'b0}}, 1'b1};
        end else begin
            w_sum = {1'b0, r_a} + {1'b0, r_b};
        end
        w_alu   = w_sum[XLEN-1:0];
        w_carry = w_sum[XLEN];
        case (r_ir_f3)
            3'b100:  begin w_alu = r_a ^ r_b; w_carry = 1'b0; end
            3'b110:  begin w_alu = r_a | r_b; w_carry = 1'b0; end
            3'b111:  begin w_alu = r_a & r_b; w_carry = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        w_bus = '0;
        case (r_state)
            c_RS1:   w_bus = w_rs1_val;
            c_RS2:   w_bus = r_ir_op ? w_rs2_val : w_imm;
            c_WB:    w_bus = w_alu;
            default: w_bus = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_ir_op   <= 1'b0;
            r_ir_sub  <= 1'b0;
            r_ir_f3   <= 3'b000;
            r_ir_rd   <= '0;
            r_ir_rs1  <= '0;
            r_ir_rs2  <= '0;
            r_ir_imm  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_pc      <= '0;
            r_carry   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.instr_valid) begin
                        if (w_legal) begin
                            r_ir_op  <= w_is_op;
                            r_ir_sub <= w_is_op && bus.instr[30];
                            r_ir_f3  <= w_f3;
                            r_ir_rd  <= bus.instr[7 +: c_RW];
                            r_ir_rs1 <= bus.instr[15 +: c_RW];
                            r_ir_rs2 <= bus.instr[20 +: c_RW];
                            r_ir_imm <= bus.instr[31:20];
                            r_state  <= c_RS1;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                c_RS1: begin
                    r_a     <= w_bus;
                    r_state <= c_RS2;
                end
                c_RS2: begin
                    r_b     <= w_bus;
                    r_state <= c_WB;
                end
                default: begin
                    r_pc    <= r_pc + c_PC_STEP;
                    r_carry <= w_carry;
                    r_done  <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if ((r_state == c_WB) && (r_ir_rd != '0)) begin
            r_rf[r_ir_rd] <= w_bus;
        end
    end

    assign bus.instr_ready = (r_state == c_IDLE);
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.done        = r_done;
    assign bus.illegal     = r_illegal;
    assign bus.pc          = r_pc;
    assign bus.databus     = w_bus;
    assign bus.alu_carry   = r_carry;
    assign bus.dbg_rdata   = (bus.dbg_raddr == '0) ? '0 : r_rf[bus.dbg_raddr];

endmodule
`default_nettype wire
